// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// RV32I funct3 size/sign encodings and the LSU state enum.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store enables/replication,
// load extraction/extension, misalignment and funct3 checks.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store lanes: shifted enables, data copied into every lane.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    if (!we) be = 4'b0000;
  end

  // Load path: pick the addressed lane, then extend.
  always_comb begin
    rbyte     = 8'(rword >> {off, 3'b000});
    rhalf     = 16'(rword >> {off[1], 4'b0000});
    rdata_ext = '0;
    case (funct3)
      F3_B:  rdata_ext = {{(XLEN-8){rbyte[7]}}, rbyte};
      F3_H:  rdata_ext = {{(XLEN-16){rhalf[15]}}, rhalf};
      F3_W:  rdata_ext = rword;
      F3_BU: rdata_ext = {{(XLEN-8){1'b0}}, rbyte};
      F3_HU: rdata_ext = {{(XLEN-16){1'b0}}, rhalf};
      default: rdata_ext = '0;
    endcase
  end

  // Access checks: halves need even, words need 4-byte alignment.
  always_comb begin
    misaligned = ((funct3[1:0] == 2'b01) && off[0])
              || ((funct3[1:0] == 2'b10) && (off != 2'b00));
    if (we)
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the ALU and the data memory port.
// One access in flight; stalls the core until the response pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            req_ready,
  output logic            stall,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  q_addr;
  logic [XLEN-1:0]  q_wdata;
  logic [XLEN-1:0]  q_rdata;
  logic [2:0]       q_f3;
  logic             q_we;
  logic             q_err;

  logic             idle;
  logic             timed_out;
  logic [2:0]       sel_f3;
  logic [1:0]       sel_off;
  logic             sel_we;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata_rep;
  logic [XLEN-1:0]  rdata_ext;
  logic             misaligned;
  logic             illegal;

  // In IDLE the checks look at the live request, afterwards at
  // the captured one, so a single steering block serves both.
  assign idle      = (state == S_IDLE);
  assign sel_f3    = idle ? funct3 : q_f3;
  assign sel_off   = idle ? addr[1:0] : q_addr[1:0];
  assign sel_we    = idle ? req_we : q_we;
  assign timed_out = (cnt == CNT_W'(TIMEOUT));
  assign stall     = req_valid & ~rsp_valid;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3    (sel_f3),
    .off       (sel_off),
    .we        (sel_we),
    .wdata     (q_wdata),
    .rword     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and all handshake/memory outputs.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nx = (misaligned || illegal) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (timed_out) begin
          state_nx = S_DONE;
        end else begin
          mem_req   = 1'b1;
          mem_we    = q_we;
          mem_addr  = {q_addr[XLEN-1:2], 2'b00};
          mem_be    = be;
          mem_wdata = wdata_rep;
          if (mem_gnt) begin
            if (q_we || mem_rvalid) state_nx = S_DONE;
            else                    state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (timed_out || mem_rvalid) state_nx = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = q_err;
        rdata     = q_rdata;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture, timeout counter and response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_rdata <= '0;
      q_f3    <= 3'b000;
      q_we    <= 1'b0;
      q_err   <= 1'b0;
    end else begin
      if (idle && req_valid) begin
        q_addr  <= addr;
        q_wdata <= wdata;
        q_f3    <= funct3;
        q_we    <= req_we;
        q_err   <= misaligned | illegal;
        q_rdata <= '0;
        cnt     <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + CNT_W'(1);
        if (timed_out) begin
          q_err   <= 1'b1;
          q_rdata <= '0;
        end else if (state == S_REQ) begin
          if (mem_gnt && !q_we && mem_rvalid)
            q_rdata <= rdata_ext;
        end else if (mem_rvalid) begin
          q_rdata <= rdata_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomised LSU bench with a transaction-level reference model.
// Driver scripts each access; one process checks every cycle.
module tb_lsu;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  lsu #(
    .XLEN(32),
    .TIMEOUT(TIMEOUT),
    .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .req_ready (req_ready),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        e_ready, e_stall, e_rv, e_err;
  logic [31:0] e_rdata;
  logic        e_mreq, e_mwe, e_chk_mem;
  logic [31:0] e_maddr, e_mwdata;
  logic [3:0]  e_mbe;
  logic [31:0] last_rdata, last_mwdata;
  logic        last_err;
  logic [3:0]  last_mbe;

  // ---------------- reference model ----------------
  function automatic bit legal(input bit we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit misal(input logic [2:0] f3,
                               input logic [1:0] off);
    return (int'(off) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [1:0] off);
    int m;
    m = ((1 << nbytes(f3)) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    r = '0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] m, v;
    int bits;
    bits = 8 * nbytes(f3);
    if (bits == 32) return w;
    m = (32'd1 << bits) - 1;
    v = (w >> (8 * int'(off))) & m;
    if (!f3[2] && ((v >> (bits - 1)) & 32'd1) != 0) v = v | ~m;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    #2;
    cmp("req_ready", 32'(req_ready), 32'(e_ready));
    cmp("stall", 32'(stall), 32'(e_stall));
    cmp("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    cmp("rsp_err", 32'(rsp_err), 32'(e_err));
    cmp("rdata", rdata, e_rdata);
    cmp("mem_req", 32'(mem_req), 32'(e_mreq));
    if (e_mreq || e_chk_mem) begin
      cmp("mem_we", 32'(mem_we), 32'(e_mwe));
      cmp("mem_addr", mem_addr, e_maddr);
      cmp("mem_be", 32'(mem_be), 32'(e_mbe));
    end
    if (e_chk_mem || (e_mreq && e_mwe))
      cmp("mem_wdata", mem_wdata, e_mwdata);
    if (rsp_valid) begin
      last_rdata = rdata;
      last_err   = rsp_err;
    end
    if (mem_req && mem_we) begin
      last_mbe    = mem_be;
      last_mwdata = mem_wdata;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input bit rdy, input bit st,
                            input bit rv, input bit er,
                            input logic [31:0] rd,
                            input bit mreq);
    e_ready = rdy; e_stall = st; e_rv = rv; e_err = er;
    e_rdata = rd;  e_mreq = mreq; e_chk_mem = 1'b0;
  endtask

  task automatic expect_reset();
    expect_out(1, 0, 0, 0, 0, 0);
    e_mwe = 0; e_maddr = 0; e_mbe = 0; e_mwdata = 0;
    e_chk_mem = 1'b1;
  endtask

  task automatic noise();
    mem_gnt    = 1'($urandom);
    mem_rvalid = 1'($urandom);
    mem_rdata  = $urandom;
  endtask

  task automatic quiet();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
  endtask

  task automatic scramble();
    req_we = 1'($urandom);
    funct3 = 3'($urandom);
    addr   = $urandom;
    wdata  = $urandom;
  endtask

  task automatic idle_cycle();
    step();
    req_valid = 1'b0;
    scramble();
    noise();
    expect_out(1, 0, 0, 0, 0, 0);
  endtask

  task automatic txn(input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] word, input int gd,
                     input int rd, input bit tmo);
    bit bad;
    logic [31:0] er;
    bad = !legal(we, f3) || misal(f3, a[1:0]);
    er  = (we || bad || tmo) ? 32'd0 : m_load(f3, a[1:0], word);
    last_rdata = 'x;
    last_err   = 1'bx;
    step();
    req_valid = 1'b1; req_we = we; funct3 = f3;
    addr = a; wdata = wd;
    noise();
    expect_out(1, 1, 0, 0, 0, 0);
    if (bad) begin
      step(); scramble(); noise();
      expect_out(0, 0, 1, 1, 0, 0);
      return;
    end
    e_mwe    = we;
    e_maddr  = {a[31:2], 2'b00};
    e_mbe    = we ? m_be(f3, a[1:0]) : 4'b0000;
    e_mwdata = m_wdata(f3, wd);
    if (tmo) begin
      repeat (TIMEOUT) begin
        step(); scramble(); quiet();
        expect_out(0, 1, 0, 0, 0, 1);
      end
      step(); scramble(); quiet();
      expect_out(0, 1, 0, 0, 0, 0);
    end else begin
      repeat (gd) begin
        step(); scramble(); quiet();
        expect_out(0, 1, 0, 0, 0, 1);
      end
      step(); scramble();
      mem_gnt    = 1'b1;
      mem_rvalid = !we && rd == 0;
      mem_rdata  = word;
      expect_out(0, 1, 0, 0, 0, 1);
      if (!we && rd > 0) begin
        repeat (rd - 1) begin
          step(); scramble(); quiet();
          expect_out(0, 1, 0, 0, 0, 0);
        end
        step(); scramble();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = word;
        expect_out(0, 1, 0, 0, 0, 0);
      end
    end
    step(); scramble(); noise();
    expect_out(0, 0, 1, tmo, er, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] lf3 [5];
    logic [2:0] f3;
    bit we;
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2;
    lf3[3] = 3'd4; lf3[4] = 3'd5;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    funct3 = 3'd0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    expect_reset();
    repeat (3) step();
    step(); rst_n = 1'b1;
    expect_reset();

    cmp("lit_lb_model", m_load(3'd0, 2'd3, 32'h80FF_0000),
        32'hFFFF_FF80);
    cmp("lit_sh_be_model", 32'(m_be(3'd1, 2'd2)), 32'hC);

    txn(0, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 0, 0, 0);
    #3 cmp("lit_lw", last_rdata, 32'hDEAD_BEEF);
    cmp("lit_lw_err", 32'(last_err), 0);

    txn(0, 3'd0, 32'h103, 0, 32'h80FF_0000, 0, 0, 0);
    #3 cmp("lit_lb", last_rdata, 32'hFFFF_FF80);
    txn(0, 3'd4, 32'h103, 0, 32'h80FF_0000, 1, 1, 0);
    #3 cmp("lit_lbu", last_rdata, 32'h0000_0080);

    txn(1, 3'd1, 32'h102, 32'h1234_ABCD, 0, 0, 0, 0);
    #3 cmp("lit_sh_be", 32'(last_mbe), 32'hC);
    cmp("lit_sh_wdata", last_mwdata, 32'hABCD_ABCD);
    cmp("lit_sh_rdata", last_rdata, 0);

    txn(0, 3'd2, 32'h101, 0, 32'h5555_5555, 0, 0, 0);
    #3 cmp("lit_mis_err", 32'(last_err), 1);
    cmp("lit_mis_rdata", last_rdata, 0);

    idle_cycle();
    txn(0, 3'd1, 32'h2002, 0, 32'hBEEF_1234, 3, 2, 0);
    #3 cmp("lit_lh_slow", last_rdata, 32'hFFFF_BEEF);

    txn(0, 3'd2, 32'h300, 0, 0, 0, 0, 1);
    #3 cmp("lit_tmo_err", 32'(last_err), 1);
    cmp("lit_tmo_rdata", last_rdata, 0);

    // Reset while waiting for read data.
    idle_cycle();
    step();
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2;
    addr = 32'h400; quiet();
    expect_out(1, 1, 0, 0, 0, 0);
    step(); mem_gnt = 1'b1;
    e_mwe = 0; e_maddr = 32'h400; e_mbe = 0;
    expect_out(0, 1, 0, 0, 0, 1);
    step(); quiet();
    expect_out(0, 1, 0, 0, 0, 0);
    step(); rst_n = 1'b0; req_valid = 1'b0;
    expect_reset();
    step(); rst_n = 1'b1;
    repeat (3) begin
      step(); mem_rvalid = 1'b1; mem_gnt = 1'b0;
      expect_reset();
    end

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else if (we) f3 = lf3[$urandom_range(0, 2)];
      else f3 = lf3[$urandom_range(0, 4)];
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 2)) idle_cycle();
      txn(we, f3, $urandom, $urandom, $urandom,
          $urandom_range(0, 4), $urandom_range(0, 4), 0);
    end
    idle_cycle();
    step();
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
